// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: data width and the retire trace record.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } retire_rec_t;

  localparam int RETIRE_REC_W = $bits(retire_rec_t);

endpackage

// File: rtl/riscv_sync_fifo.sv
// Generic synchronous FIFO: DEPTH x WIDTH storage, wrap-bit pointers,
// full/empty/level, and a look-ahead read of the entry behind the head.
module riscv_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         next_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_idx, rd_idx, rd_nxt_idx;
  logic             do_push, do_pop;

  assign wr_idx     = wr_ptr_q[AW-1:0];
  assign rd_idx     = rd_ptr_q[AW-1:0];
  assign rd_nxt_idx = rd_idx + AW'(1);

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_idx];
  assign next_o  = mem_q[rd_nxt_idx];

  // Pop needs data; push needs a slot, which a same-cycle pop frees.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_idx] <= wdata_i;
  end

endmodule

// File: rtl/riscv_retire_buffer.sv
// Retire trace buffer: queues core retire records, drains them over
// valid/ready through a registered head, counts retires and drops.
module riscv_retire_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    update_i,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [XLEN-1:0]         instr_i,
  input  logic [4:0]              reg_addr_i,
  input  logic [XLEN-1:0]         reg_data_i,
  input  logic [XLEN-1:0]         mem_addr_i,
  input  logic [XLEN-1:0]         mem_data_i,
  input  logic                    clear_i,
  output logic                    rec_valid_o,
  input  logic                    rec_ready_i,
  output retire_rec_t             rec_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic [CNT_W-1:0]        retire_cnt_o,
  output logic [CNT_W-1:0]        drop_cnt_o,
  output logic                    overflow_o
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  retire_rec_t             in_rec, fifo_head, fifo_next;
  retire_rec_t             rec_q, rec_d;
  logic [0:0]              state_q, state_d;
  logic                    fifo_full, fifo_empty, push, pop, drop_ev;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic [CNT_W-1:0]        retire_cnt_q, retire_cnt_d, drop_cnt_q, drop_cnt_d;
  logic                    overflow_q, overflow_d;

  assign in_rec = '{pc: pc_i, instr: instr_i, rd: reg_addr_i, rd_data: reg_data_i,
                    mem_addr: mem_addr_i, mem_data: mem_data_i};

  // The output register mirrors the FIFO head, so valid means non-empty.
  assign pop     = (state_q == ST_VALID) && rec_ready_i;
  assign push    = update_i && (!fifo_full || pop);
  assign drop_ev = update_i && fifo_full && !pop;

  riscv_sync_fifo #(.DEPTH(DEPTH), .WIDTH(RETIRE_REC_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_rec),
    .head_o  (fifo_head),
    .next_o  (fifo_next),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Output register FSM: load head on arrival, reload the next entry on pop.
  // On a pop with one entry left, the only possible successor is the
  // record being pushed this same cycle.
  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    if (state_q == ST_EMPTY) begin
      if (!fifo_empty) begin
        rec_d   = fifo_head;
        state_d = ST_VALID;
      end else if (push) begin
        rec_d   = in_rec;
        state_d = ST_VALID;
      end
    end else if (pop) begin
      if (fifo_level > ($clog2(DEPTH)+1)'(1)) rec_d = fifo_next;
      else if (push)                          rec_d = in_rec;
      else                                    state_d = ST_EMPTY;
    end
  end

  // Counters and sticky overflow; clear takes priority over any increment.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q;
    if (clear_i) begin
      retire_cnt_d = '0;
      drop_cnt_d   = '0;
      overflow_d   = 1'b0;
    end else begin
      if (update_i) retire_cnt_d = retire_cnt_q + CNT_W'(1);
      if (drop_ev) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_EMPTY;
      rec_q        <= '0;
      retire_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rec_q        <= rec_d;
      retire_cnt_q <= retire_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign rec_valid_o  = (state_q == ST_VALID);
  assign rec_o        = rec_q;
  assign level_o      = fifo_level;
  assign retire_cnt_o = retire_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_riscv_retire_buffer.sv
// Directed + random bench for riscv_retire_buffer against a queue model.
module tb_riscv_retire_buffer;
  import riscv_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              update_i = 1'b0, clear_i = 1'b0, rec_ready_i = 1'b0;
  logic [XLEN-1:0]   pc_i = '0, instr_i = '0, reg_data_i = '0, mem_addr_i = '0, mem_data_i = '0;
  logic [4:0]        reg_addr_i = '0;
  logic              rec_valid_o, overflow_o;
  retire_rec_t       rec_o;
  logic [LW-1:0]     level_o;
  logic [CNT_W-1:0]  retire_cnt_o, drop_cnt_o;

  riscv_retire_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
    .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .clear_i(clear_i), .rec_valid_o(rec_valid_o),
    .rec_ready_i(rec_ready_i), .rec_o(rec_o), .level_o(level_o),
    .retire_cnt_o(retire_cnt_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Reference model: queue of records plus plain counters.
  retire_rec_t      mq[$];
  retire_rec_t      m_last;
  logic [CNT_W-1:0] m_retire, m_drop;
  logic             m_ovf;
  int               errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0; m_retire = '0; m_drop = '0; m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic upd, input logic rdy, input logic clr, input retire_rec_t r);
    bit do_pop, do_push;
    do_pop  = (mq.size() > 0) && rdy;
    do_push = upd && ((mq.size() - int'(do_pop)) < DEPTH);
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(r);
    if (clr) begin
      m_retire = '0; m_drop = '0; m_ovf = 1'b0;
    end else begin
      if (upd) m_retire = m_retire + 1;
      if (upd && !do_push) begin
        m_ovf = 1'b1;
        if (m_drop != '1) m_drop = m_drop + 1;
      end
    end
    if (mq.size() > 0) m_last = mq[0];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},  192'(rec_valid_o),  192'(mq.size() > 0));
    chk({tag, ".level"},  192'(level_o),      192'(mq.size()));
    chk({tag, ".rec"},    192'(rec_o),        192'(m_last));
    chk({tag, ".retire"}, 192'(retire_cnt_o), 192'(m_retire));
    chk({tag, ".drop"},   192'(drop_cnt_o),   192'(m_drop));
    chk({tag, ".ovf"},    192'(overflow_o),   192'(m_ovf));
  endtask

  function automatic retire_rec_t mk(input logic [XLEN-1:0] pc);
    retire_rec_t r;
    r.pc = pc; r.instr = $urandom; r.rd = 5'($urandom);
    r.rd_data = $urandom; r.mem_addr = $urandom; r.mem_data = $urandom;
    return r;
  endfunction

  // One clock: drive at negedge, step model at posedge, check 1ns later.
  task automatic cyc(input string tag, input logic upd, input logic rdy, input logic clr,
                     input retire_rec_t r);
    @(negedge clk);
    update_i = upd; rec_ready_i = rdy; clear_i = clr;
    pc_i = r.pc; instr_i = r.instr; reg_addr_i = r.rd; reg_data_i = r.rd_data;
    mem_addr_i = r.mem_addr; mem_data_i = r.mem_data;
    @(posedge clk);
    model_step(upd, rdy, clr, r);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    update_i = 1'b0; rec_ready_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_i = 1'b1;
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * DEPTH + 4 && mq.size() > 0; i++) cyc(tag, 1'b0, 1'b1, 1'b0, '0);
    chk({tag, ".empty"}, 192'(level_o), 192'(0));
  endtask

  initial begin
    retire_rec_t r, prev;
    int          nupd;
    logic        u, rd;
    logic        was_stall;

    // Reset state
    model_reset();
    #2;
    check_all("reset_async");
    do_reset();
    #1;
    check_all("reset");

    // Single record: visible one cycle after the push edge, popped the next
    r = '{pc: 32'h8000_0000, instr: 32'h0050_0093, rd: 5'd1, rd_data: 32'd5,
          mem_addr: 32'd0, mem_data: 32'd0};
    cyc("single_push", 1'b1, 1'b1, 1'b0, r);
    chk("single_pc", 192'(rec_o.pc), 192'(32'h8000_0000));
    chk("single_valid", 192'(rec_valid_o), 192'(1));
    cyc("single_pop", 1'b0, 1'b1, 1'b0, '0);
    chk("single_retire", 192'(retire_cnt_o), 192'(1));

    // Fill to DEPTH, then overflow by one; drain in order
    do_reset();
    for (int k = 0; k < DEPTH; k++) cyc("fill", 1'b1, 1'b0, 1'b0, mk(32'h8000_0000 + 32'(4 * k)));
    chk("fill_level", 192'(level_o), 192'(DEPTH));
    chk("fill_ovf", 192'(overflow_o), 192'(0));
    cyc("ovf_push", 1'b1, 1'b0, 1'b0, mk(32'h8000_0040));
    chk("ovf_drop", 192'(drop_cnt_o), 192'(1));
    chk("ovf_flag", 192'(overflow_o), 192'(1));
    chk("ovf_retire", 192'(retire_cnt_o), 192'(DEPTH + 1));
    for (int k = 0; k < DEPTH; k++) begin
      chk("drain_pc", 192'(rec_o.pc), 192'(32'h8000_0000 + 32'(4 * k)));
      cyc("drain", 1'b0, 1'b1, 1'b0, '0);
    end
    chk("drain_empty", 192'(rec_valid_o), 192'(0));

    // Full with simultaneous push and pop: no drop, new record last
    do_reset();
    for (int k = 0; k < DEPTH; k++) cyc("fill2", 1'b1, 1'b0, 1'b0, mk(32'h1000 + 32'(4 * k)));
    cyc("full_pushpop", 1'b1, 1'b1, 1'b0, mk(32'h2000));
    chk("full_pushpop_level", 192'(level_o), 192'(DEPTH));
    chk("full_pushpop_drop", 192'(drop_cnt_o), 192'(0));
    drain("drain2");

    // Random back-pressure, 200 updates at ~50% density
    do_reset();
    nupd = 0;
    was_stall = 1'b0;
    prev = '0;
    for (int c = 0; c < 2000 && nupd < 200; c++) begin
      u  = 1'($urandom);
      rd = 1'($urandom);
      if (u) nupd++;
      cyc("rand", u, rd, 1'b0, mk($urandom));
      if (was_stall) chk("rand_stable", 192'(rec_o), 192'(prev));
      was_stall = rec_valid_o && !rd;
      prev = rec_o;
      // the next cycle's ready decides stall; re-evaluate below by peeking ahead
      was_stall = 1'b0;
    end
    // explicit stall stability check
    if (mq.size() == 0) cyc("stall_fill", 1'b1, 1'b0, 1'b0, mk(32'h3000));
    prev = rec_o;
    for (int k = 0; k < 3; k++) begin
      cyc("stall", 1'b1, 1'b0, 1'b0, mk($urandom));
      chk("stall_stable", 192'(rec_o), 192'(prev));
    end
    drain("drain_rand");

    // Async reset mid-cycle with 5 queued records
    do_reset();
    for (int k = 0; k < 5; k++) cyc("pre_rst", 1'b1, 1'b0, 1'b0, mk(32'h4000 + 32'(4 * k)));
    @(negedge clk);
    idle();
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    check_all("mid_rst");
    @(negedge clk);
    rst_i = 1'b0;
    r = mk(32'h5000);
    cyc("post_rst", 1'b1, 1'b0, 1'b0, r);
    chk("post_rst_pc", 192'(rec_o.pc), 192'(32'h5000));

    // Clear coincident with an overflowing update
    do_reset();
    for (int k = 0; k < DEPTH; k++) cyc("fill3", 1'b1, 1'b0, 1'b0, mk(32'h6000 + 32'(4 * k)));
    cyc("clr_ovf", 1'b1, 1'b0, 1'b1, mk(32'h7000));
    chk("clr_drop", 192'(drop_cnt_o), 192'(0));
    chk("clr_ovf_flag", 192'(overflow_o), 192'(0));
    chk("clr_level", 192'(level_o), 192'(DEPTH));
    drain("drain3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
